// File: rtl/gerador_sequencia.sv
// Up-counting sequence generator (0..CONST) with terminal-count flag, one-shot or continuous.
// Optional GERADOR_SEQUENCIA_UPDOWN_EN adds a latched `dir` input for down-counting (CONST..0).
module gerador_sequencia #(
    parameter int CONST = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef GERADOR_SEQUENCIA_UPDOWN_EN
    input  logic             dir,
`endif
    input  logic             start,
    input  logic             mode,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    if (CONST < 0 || longint'(CONST) > (longint'(1) << WIDTH) - 1) begin : g_bad_const
        $error("gerador_sequencia: CONST does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] CONST_V = WIDTH'(CONST);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             dir_in;
    logic             valid_d, busy_d, done_d;
    logic [WIDTH-1:0] first_val, last_val, load_val;

`ifdef GERADOR_SEQUENCIA_UPDOWN_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    // Sequence endpoints follow the direction latched at the accepted start.
    assign first_val = dir_q  ? CONST_V : '0;
    assign last_val  = dir_q  ? '0 : CONST_V;
    assign load_val  = dir_in ? CONST_V : '0;

    assign tc = valid && (out == last_val);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out     <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        out_d   = out;
        mode_d  = mode_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (start && !stop) begin
                    state_d = RUN;
                    out_d   = load_val;
                    mode_d  = mode;
                    dir_d   = dir_in;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    out_d   = '0;
                end else if (en) begin
                    if (out != last_val)
                        out_d = dir_q ? out - WIDTH'(1) : out + WIDTH'(1);
                    else if (mode_q)
                        out_d = first_val;
                    else
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                out_d   = '0;
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    // Flag outputs are decoded from the next state and registered alongside it.
    always_comb begin
        valid_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

endmodule

// File: doc/gerador_sequencia.md
Name: gerador_sequencia

Overview:
- Sequence generator that drives an equality comparator.
- Produces an up-count from 0 to the constant CONST, flags the terminal value, and either stops (one-shot) or wraps (continuous).
- Used as the stimulus/timing source for blocks that detect `value == CONST`; the generator and the detector share the CONST and WIDTH parameters.

Parameters:
- CONST, 10, terminal value of the sequence; legal range 0..2**WIDTH-1; elaboration fails (generate-time error) otherwise.
- WIDTH, 4, width of the generated value in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begin a sequence; sampled only in IDLE.
- mode  input  1  0 = one-shot, 1 = continuous; latched on accepted start.
- stop  input  1  abort current sequence; highest priority after reset.
- en  input  1  advance enable; the value advances only when en=1 in RUN.
- out  output  WIDTH  current generated value.
- valid  output  1  out carries a sequence value.
- tc  output  1  terminal count: combinational, valid && (out == CONST).
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - out=0, valid=0, busy=0, done=0; tc therefore 0.
  - Latched mode=0.
  - Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, DONE (registered FSM; busy, valid and done are registered).
- IDLE:
  - start=1 and stop=0 → RUN next cycle, with out=0, valid=1, busy=1, and mode latched.
  - Otherwise remain in IDLE with out=0 and valid=0.
  - If start and stop are both high, stop wins and the FSM stays in IDLE.
- RUN, evaluated in priority order:
  1. stop=1 → IDLE next cycle; out=0, valid=0, busy=0; no done pulse.
  2. en=0 → hold out; tc stays high if out==CONST.
  3. en=1 and out!=CONST → out=out+1.
  4. en=1, out==CONST, latched mode=1 → out wraps to 0; remain in RUN with no gap in valid.
  5. en=1, out==CONST, latched mode=0 → DONE next cycle; out holds CONST, valid=0, busy=0, done=1.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Then IDLE with done=0 and out=0.
  - A start presented in DONE is ignored.
- start is ignored in RUN.
- mode changes after start have no effect until the next accepted start.
- Latency:
  - start to first valid value is 1 cycle.
  - One-shot with en held high: valid for CONST+1 cycles (values 0..CONST); done asserts the cycle after the CONST value.
- CONST=0:
  - Every enabled RUN cycle is terminal and tc=1 whenever valid.
  - One-shot produces the single value 0.
- Arithmetic is unsigned, WIDTH bits; overflow is impossible because CONST ≤ 2**WIDTH-1.

Optional Feature:
- Macro: GERADOR_SEQUENCIA_UPDOWN_EN.
- Defined:
  - Adds input port `dir` (1 bit), latched together with mode on an accepted start.
  - dir=0 behaves exactly as above.
  - dir=1: start loads out=CONST, each enabled cycle decrements, and the terminal value is 0 (tc = valid && out==0).
  - In continuous mode with dir=1, out wraps to CONST after 0; one-shot completes after 0.
- Undefined:
  - Port `dir` is absent and the block counts up only.
  - Logic is identical to dir=0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and en=1 → out=0, valid=busy=done=tc=0 throughout; release → IDLE, out=0.
- One-shot, CONST=10, WIDTH=4, en=1 constant, start pulse → out=0..10 on 11 consecutive valid cycles; tc=1 only on out=10; done=1 the cycle after; busy falls together with valid.
- Continuous, CONST=3: start with mode=1, en=1, run 10 cycles → out=0,1,2,3,0,1,2,3,0,1; tc high on each 3; done never asserts.
- en gating and stop: one-shot with en toggling 1,0,1,0 → each value held for 2 cycles; assert stop at out=5 → next cycle IDLE, out=0, valid=0, no done.
- Illegal-time inputs: start during RUN at out=4 → sequence continues 5,6,…; start+stop together in IDLE → stays IDLE; rst_n=0 at out=7 → all outputs zero next cycle.
- With GERADOR_SEQUENCIA_UPDOWN_EN, dir=1, one-shot, CONST=10 → out=10..0; tc only on 0; done pulse after 0. Continuous dir=1, CONST=2 → 2,1,0,2,1,0.
